// File: rtl/simon_pkg.sv
// Shared types and sizes for the Simon Says datapath (memory, blinker, checker).
package simon_pkg;

  localparam int COLOR_W   = 2;
  localparam int ADDR_W    = 4;
  localparam int MEM_DEPTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_FETCH        = 3'd1,
    ST_WAIT_PRESS   = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_DONE         = 3'd4
  } chk_state_t;

  function automatic logic is_checking(input chk_state_t s);
    return (s == ST_FETCH) || (s == ST_WAIT_PRESS) || (s == ST_WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/simon_input_checker_btn_encode.sv
// Button-level encoder: one-hot colour to index, plus exactly-one / none qualifiers.
module btn_encode
  import simon_pkg::*;
(
  input  logic [3:0]         btn_i,
  output logic [COLOR_W-1:0] idx_o,
  output logic               single_o,
  output logic               none_o
);

  assign none_o   = (btn_i == 4'd0);
  // x & (x-1) clears the lowest set bit; zero result means at most one bit was set
  assign single_o = !none_o && ((btn_i & (btn_i - 4'd1)) == 4'd0);
  assign idx_o    = {btn_i[3] | btn_i[2], btn_i[3] | btn_i[1]};

endmodule

// File: rtl/simon_input_checker.sv
// Player-response checker: walks the stored colour sequence and grades one press per element.
module simon_input_checker
  import simon_pkg::*;
#(
  parameter int MAX_LEVEL      = MEM_DEPTH,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  level,
  input  logic [3:0]         buttons,
  input  logic [COLOR_W-1:0] mem_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [3:0]         echo_led
);

  localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] MAX_LVL  = ADDR_W'(MAX_LEVEL);

  chk_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  lvl_q, lvl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               tmo_q, tmo_d;
  logic [3:0]         echo_q, echo_d;

  logic [COLOR_W-1:0] btn_idx;
  logic               btn_single;
  logic               btn_none;
  logic               start_ok;

  btn_encode u_enc (
    .btn_i    (buttons),
    .idx_o    (btn_idx),
    .single_o (btn_single),
    .none_o   (btn_none)
  );

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;

    if (start_ok) begin
      lvl_d  = (level > MAX_LVL) ? MAX_LVL : level;
      idx_d  = '0;
      pass_d = 1'b0;
      fail_d = 1'b0;
      tmo_d  = 1'b0;
      if (lvl_d == '0) begin
        state_d = ST_DONE;
        pass_d  = 1'b1;
      end else begin
        state_d = ST_FETCH;
        addr_d  = '0;
      end
    end else begin
      unique case (state_q)
        // Only a press that starts from all-released counts for this element.
        ST_FETCH: begin
          if (btn_none) begin
            state_d = ST_WAIT_PRESS;
            cnt_d   = '0;
          end
        end
        ST_WAIT_PRESS: begin
          if (btn_none) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_DONE;
              fail_d  = 1'b1;
              tmo_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (btn_single && (btn_idx == mem_data)) begin
            state_d = ST_WAIT_RELEASE;
          end else begin
            state_d = ST_DONE;
            fail_d  = 1'b1;
          end
        end
        ST_WAIT_RELEASE: begin
          if (btn_none) begin
            if (idx_q == lvl_q - 1'b1) begin
              state_d = ST_DONE;
              pass_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              addr_d  = idx_q + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = is_checking(state_d);
    done_d = (state_d == ST_DONE);
    echo_d = busy_d ? buttons : 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      echo_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      echo_q  <= echo_d;
    end
  end

  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = tmo_q;
  assign echo_led = echo_q;

endmodule

// File: tb/tb_simon_input_checker.sv
// Bench for simon_input_checker: scripted button traces graded by a per-element round model.
module tb_simon_input_checker;

  localparam int TO = 20;

  logic       clk, reset, start;
  logic [3:0] level, buttons;
  logic [1:0] mem_data;
  logic [3:0] mem_addr, echo_led;
  logic       busy, done, pass, fail, timeout;

  logic [1:0] mem [16];
  logic [3:0] bq [$];
  int         rel_q [$];
  int         m_tdone;
  bit         m_pass, m_fail, m_to;
  int         n_vec, n_err;

  simon_input_checker #(.MAX_LEVEL(10), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .level(level), .buttons(buttons),
    .mem_data(mem_data), .mem_addr(mem_addr), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .echo_led(echo_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] get_b(input int t);
    return (t < bq.size()) ? bq[t] : 4'd0;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] c);
    logic [3:0] v;
    v = 4'd0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic int addr_at(input int t);
    int n;
    n = 0;
    foreach (rel_q[i]) if (rel_q[i] <= t) n++;
    return n;
  endfunction

  task automatic push_elem(input int gap, input logic [3:0] v, input int hold);
    repeat (gap) bq.push_back(4'd0);
    repeat (hold) bq.push_back(v);
    bq.push_back(4'd0);
  endtask

  // Edge 0 samples start; edge t samples bq[t]. Walk element by element through the trace.
  task automatic model(input int eff);
    int t, idle;
    logic [3:0] v;
    rel_q.delete();
    m_pass = 0; m_fail = 0; m_to = 0; m_tdone = 0;
    if (eff == 0) begin m_pass = 1; return; end
    t = 1;
    for (int k = 0; k < eff; k++) begin
      while (get_b(t) != 0) t++;
      t++;
      idle = 0;
      while (get_b(t) == 0) begin
        if (idle == TO - 1) begin m_tdone = t; m_fail = 1; m_to = 1; return; end
        idle++;
        t++;
      end
      v = get_b(t);
      if ($countones(v) != 1 || v != onehot(mem[k])) begin m_tdone = t; m_fail = 1; return; end
      t++;
      while (get_b(t) != 0) t++;
      if (k == eff - 1) begin m_tdone = t; m_pass = 1; return; end
      rel_q.push_back(t);
      t++;
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_round(input logic [3:0] lvl, input int abort_at, input bit spur_en);
    int eff, spur;
    bit bsy;
    eff = (lvl > 4'd10) ? 10 : int'(lvl);
    model(eff);
    spur = (spur_en && m_tdone > 1) ? $urandom_range(0, m_tdone - 1) : -1;
    start = 1'b1; level = lvl; buttons = get_b(0);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t <= m_tdone + 3; t++) begin
      if (t == abort_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);   chk("rst_fail", fail, 0);
        chk("rst_tmo", timeout, 0); chk("rst_echo", echo_led, 0);
        chk("rst_addr", mem_addr, 0);
        buttons = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      bsy = (t < m_tdone);
      chk("busy", busy, bsy);
      chk("done", done, !bsy);
      chk("pass", pass, !bsy && m_pass);
      chk("fail", fail, !bsy && m_fail);
      chk("timeout", timeout, !bsy && m_to);
      chk("echo", echo_led, bsy ? get_b(t) : 4'd0);
      if (eff != 0) chk("addr", mem_addr, addr_at(t));
      start = (t == spur);
      if (start) level = 4'($urandom_range(0, 15));
      buttons = get_b(t + 1);
      @(negedge clk);
    end
    start = 1'b0;
    buttons = 4'd0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int gap, hold, sel;
    logic [3:0] lvl, v;
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; level = 4'd0; buttons = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst0_busy", busy, 0); chk("rst0_done", done, 0); chk("rst0_pass", pass, 0);
    chk("rst0_fail", fail, 0); chk("rst0_tmo", timeout, 0); chk("rst0_echo", echo_led, 0);
    chk("rst0_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2; mem[3] = 2'd3; mem[4] = 2'd0; mem[5] = 2'd1;

    // all four correct, held 3 cycles each
    bq.delete(); bq.push_back(4'd0);
    push_elem(1, 4'b0001, 3); push_elem(1, 4'b0010, 3);
    push_elem(1, 4'b0100, 3); push_elem(1, 4'b1000, 3);
    run_round(4'd4, -1, 0);

    // wrong colour on element 1
    bq.delete(); bq.push_back(4'd0);
    push_elem(1, 4'b0001, 2); push_elem(1, 4'b0100, 2);
    run_round(4'd4, -1, 0);

    // two buttons at once on element 0
    bq.delete(); bq.push_back(4'd0);
    push_elem(2, 4'b0011, 2);
    run_round(4'd4, -1, 0);

    // no press at all
    bq.delete(); bq.push_back(4'd0);
    run_round(4'd4, -1, 0);

    // level 0, then level 15 clamped to 10
    bq.delete(); bq.push_back(4'd0);
    run_round(4'd0, -1, 0);
    for (int i = 6; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
    bq.delete(); bq.push_back(4'd0);
    for (int k = 0; k < 12; k++) push_elem(1, onehot(mem[k]), 1);
    run_round(4'd15, -1, 0);

    // button already held across start
    bq.delete(); bq.push_back(4'b0010); bq.push_back(4'b0010); bq.push_back(4'b0010);
    for (int k = 0; k < 4; k++) push_elem(1, onehot(mem[k]), 2);
    run_round(4'd4, -1, 0);

    // reset while element 2 is held, then a clean round from address 0
    bq.delete(); bq.push_back(4'd0);
    push_elem(1, onehot(mem[0]), 2); push_elem(1, onehot(mem[1]), 2);
    push_elem(1, onehot(mem[2]), 10);
    run_round(4'd4, 12, 0);
    bq.delete(); bq.push_back(4'd0);
    for (int k = 0; k < 4; k++) push_elem(1, onehot(mem[k]), 1);
    run_round(4'd4, -1, 0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
      lvl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
      bq.delete(); bq.push_back(4'd0);
      if ($urandom_range(0, 4) == 0)
        repeat ($urandom_range(1, 3)) bq.push_back(4'($urandom_range(1, 15)));
      for (int k = 0; k < 10; k++) begin
        sel  = $urandom_range(0, 99);
        gap  = (sel < 3) ? 25 : (sel < 8) ? 0 : $urandom_range(1, 3);
        v    = ($urandom_range(0, 99) < 88) ? onehot(mem[k]) : 4'($urandom_range(1, 15));
        hold = $urandom_range(1, 3);
        push_elem(gap, v, hold);
      end
      run_round(lvl, -1, ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simon_input_checker.md
# simon_input_checker

Player-response checker for the Simon Says game; the receiving end of the sequence that the blinker plays out. After the game FSM pulses `start`, it walks the stored colour sequence in the shared 2-bit memory one address at a time, waits for a single button press per element and compares it with the stored colour. It reports pass, wrong-button fail or timeout fail back to the FSM.

## Interface
Parameters:
- `MAX_LEVEL`, 10: memory depth; effective level is clamped to this.
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles allowed per element before timeout fail.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse from the FSM; begins a check round. Accepted in IDLE or DONE only.
- `level`  in  4  sequence length to check; sampled on `start`.
- `buttons`  in  4  synchronized, debounced button levels, active-high; bit i = colour i.
- `mem_data`  in  2  colour read from memory (`out_num`). Valid one cycle after `mem_addr` changes.
- `mem_addr`  out  4  read address to memory, the current element index.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  held high in DONE.
- `pass`  out  1  held high in DONE when all elements matched.
- `fail`  out  1  held high in DONE on wrong, multiple or late press.
- `timeout`  out  1  held high with `fail` when the failure cause was timeout.
- `echo_led`  out  4  registered copy of `buttons` while checking; 0 otherwise.

## Operation
- States: IDLE, FETCH, WAIT_PRESS, WAIT_RELEASE, DONE.
- IDLE/DONE + `start`:
  - latch `eff_level = min(level, MAX_LEVEL)`; clear `idx`, `done`, `pass`, `fail`, `timeout`.
  - If `eff_level==0`, go to DONE with `pass=1`. Otherwise go to FETCH.
- FETCH:
  - `mem_addr=idx`; stay for at least one cycle so that `mem_data` settles.
  - Stay while `buttons!=0`; only a press from the all-released state counts.
  - Then go to WAIT_PRESS and clear the timeout counter.
- WAIT_PRESS, evaluated on each sampled `buttons`:
  - `buttons==0`: increment the counter. When the counter reaches `TIMEOUT_CYCLES-1`, go to DONE with `fail=1, timeout=1`.
  - Exactly one bit set, with encoded index == `mem_data`: go to WAIT_RELEASE.
  - Exactly one bit set, with index != `mem_data`: go to DONE with `fail=1`.
  - More than one bit set: go to DONE with `fail=1`.
- WAIT_RELEASE:
  - Wait for `buttons==0`; this wait has no timeout.
  - On release, if `idx==eff_level-1`, go to DONE with `pass=1`. Otherwise `idx<=idx+1` and go to FETCH.
- DONE:
  - Hold all flags and `mem_addr`.
  - `start` restarts the round, with the same behaviour as from IDLE.
  - `start` in any other state is ignored.
- `pass` and `fail` are never high together. `timeout` implies `fail`.

## Timing
- Reset values: `mem_addr=0`, `busy=0`, `done=0`, `pass=0`, `fail=0`, `timeout=0`, `echo_led=0`; state IDLE.
- Reset mid-round aborts immediately to these values. No partial result is reported.
- All outputs are registered.
- `start` at edge N gives `busy=1` and state FETCH at N+1.
- The deciding `buttons` sample at edge N gives the outcome flags and `done` at N+1. `busy` drops at the same edge.
- Minimum round length for level L with immediate presses: 3 cycles per element (FETCH, WAIT_PRESS, WAIT_RELEASE) plus 1 cycle to DONE.
- `mem_addr` changes only on entry to FETCH, so `mem_data` is stable for every comparison.
- The timeout counter is `$clog2(TIMEOUT_CYCLES)` bits wide. It resets on every entry to WAIT_PRESS and does not count in other states.

## Structure
- `simon_pkg`: state enum `chk_state_t`, `COLOR_W=2`, `ADDR_W=4`, `MEM_DEPTH=10`. The memory and blinker share the same package.
- Sub-module `btn_encode`: combinational; 4-bit one-hot to 2-bit index plus `single` (exactly one bit set) and `none` (all zero).
- Top: FSM, index register, timeout counter, flag registers.

## Test plan
- Memory preloaded 0,1,2,3,0,1 with level=4; presses 1,2,4,8 (one-hot), each held 3 cycles and released → `pass=1` and `done=1` after the 4th release. `mem_addr` steps 0..3.
- Same preload, level=4, second press 4'b0100 (expected 1) → `fail=1`, `timeout=0` one cycle after that sample. `mem_addr=1`.
- Press 4'b0011 on element 0 → `fail=1`.
- `TIMEOUT_CYCLES=20`, no press → `fail=1`, `timeout=1` exactly 20 cycles after WAIT_PRESS entry.
- `level=0` → `pass=1` at `start`+1. Then `level=15` → eff_level 10 and `mem_addr` reaches 9 max.
- Button held during `start`: no evaluation until release. Reset asserted during WAIT_RELEASE of element 2 → all outputs 0 and state IDLE asynchronously. A following `start` restarts at `mem_addr=0`.
